// File: rtl/ser_arb_pkg.sv
// ser_arb_pkg: shared types and constants for the UART transmit arbiter.
//   arb_state_e  - arbiter FSM states (idle / sending / line-locked)
//   ASCII_LF     - end-of-line byte that releases a line lock
//   NUM_REQ_MAX  - upper bound on the number of requesters
//   rr_next()    - round-robin successor of an index
package ser_arb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSend = 2'd1,
        StLock = 2'd2
    } arb_state_e;

    localparam logic [7:0]  ASCII_LF    = 8'h0A;
    localparam int unsigned NUM_REQ_MAX = 4;

    // (idx + 1) mod n, for idx < n.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/ser_tx_arbiter_if.sv
// ser_tx_arbiter_if: requester lanes plus the UART data-register write port.
//   req_valid/req_data/req_ready - per-lane byte handshake (lane i = req_data[8i+7:8i])
//   uart_we/uart_dat/uart_wait   - UART data-register write strobe, byte, busy
//   owner/locked                 - last grantee index and line-lock status
// Modports: master = arbiter side, slave = requesters + UART side.
interface ser_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 2
);
    localparam int unsigned IdxW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 uart_we;
    logic [7:0]           uart_dat;
    logic                 uart_wait;
    logic [IdxW-1:0]      owner;
    logic                 locked;

    modport master (
        input  req_valid, req_data, uart_wait,
        output req_ready, uart_we, uart_dat, owner, locked
    );

    modport slave (
        output req_valid, req_data, uart_wait,
        input  req_ready, uart_we, uart_dat, owner, locked
    );

endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority picker.
//   req_i   - request vector
//   start_i - index with highest priority; priority descends upward, wrapping
//   gnt_o   - one-hot grant (zero when no request)
//   idx_o   - index of the granted request
//   any_o   - at least one request present
module rr_pick #(
    parameter int unsigned N    = 2,
    parameter int unsigned IdxW = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] start_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] idx_o,
    output logic            any_o
);

    // One extra bit so start + offset cannot overflow before the wrap.
    logic [IdxW:0] pos;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        pos   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = {1'b0, start_i} + (IdxW + 1)'(k);
            if (pos >= (IdxW + 1)'(N)) begin
                pos = pos - (IdxW + 1)'(N);
            end
            if (!any_o && req_i[pos[IdxW-1:0]]) begin
                any_o                 = 1'b1;
                gnt_o[pos[IdxW-1:0]]  = 1'b1;
                idx_o                 = pos[IdxW-1:0];
            end
        end
    end

endmodule

// File: rtl/ser_tx_arbiter.sv
// ser_tx_arbiter: round-robin arbiter sharing one UART transmitter among NUM_REQ
// byte-stream requesters. A granted byte is held and written to the UART until
// accepted (uart_we high, uart_wait low).
// Ports:
//   clk    - system clock
//   resetn - synchronous active-low reset
//   bus    - ser_tx_arbiter_if.master (requester lanes, UART write port, owner, locked)
// Parameters:
//   NUM_REQ      - requesters, 2..4
//   LOCK_TIMEOUT - idle cycles a line lock survives (lock build only)
// Build option: define SER_ARB_LOCK_EN to keep a grant until LF so text lines
// from different sources never interleave.
module ser_tx_arbiter
    import ser_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned LOCK_TIMEOUT = 4096
) (
    input logic             clk,
    input logic             resetn,
    ser_tx_arbiter_if.master bus
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > NUM_REQ_MAX) begin : g_bad_num_req
        $error("ser_tx_arbiter: NUM_REQ out of range");
    end
    if (LOCK_TIMEOUT < 2) begin : g_bad_timeout
        $error("ser_tx_arbiter: LOCK_TIMEOUT must be at least 2");
    end

    arb_state_e         state_q, state_d;
    logic [IdxW-1:0]    owner_q, owner_d;
    logic [7:0]         hold_q, hold_d;
    logic [IdxW-1:0]    start_idx;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [IdxW-1:0]    pick_idx;
    logic               pick_any;
    logic [NUM_REQ-1:0] req_ready;

`ifdef SER_ARB_LOCK_EN
    localparam int unsigned TmrW = $clog2(LOCK_TIMEOUT);

    logic [TmrW-1:0]    tmr_q, tmr_d;
    logic               lock_q, lock_d;
    logic [NUM_REQ-1:0] owner_oh;

    assign owner_oh = NUM_REQ'(1) << owner_q;
`endif

    // The owner just served drops to lowest priority.
    assign start_idx = IdxW'(rr_next(32'(owner_q), NUM_REQ));

    rr_pick #(
        .N    (NUM_REQ),
        .IdxW (IdxW)
    ) u_rr_pick (
        .req_i   (bus.req_valid),
        .start_i (start_idx),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
            owner_q <= '0;
            hold_q  <= 8'h00;
`ifdef SER_ARB_LOCK_EN
            tmr_q   <= '0;
            lock_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
`ifdef SER_ARB_LOCK_EN
            tmr_q   <= tmr_d;
            lock_q  <= lock_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        hold_d  = hold_q;
`ifdef SER_ARB_LOCK_EN
        tmr_d   = tmr_q;
        lock_d  = lock_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    state_d = StSend;
                    owner_d = pick_idx;
                    hold_d  = bus.req_data[8*pick_idx +: 8];
                end
            end
            StSend: begin
                if (!bus.uart_wait) begin
`ifdef SER_ARB_LOCK_EN
                    if (hold_q == ASCII_LF) begin
                        state_d = StIdle;
                        lock_d  = 1'b0;
                    end else begin
                        state_d = StLock;
                        lock_d  = 1'b1;
                        tmr_d   = '0;
                    end
`else
                    state_d = StIdle;
`endif
                end
            end
`ifdef SER_ARB_LOCK_EN
            StLock: begin
                if (bus.req_valid[owner_q]) begin
                    state_d = StSend;
                    hold_d  = bus.req_data[8*owner_q +: 8];
                    tmr_d   = '0;
                end else if (tmr_q == TmrW'(LOCK_TIMEOUT - 1)) begin
                    state_d = StIdle;
                    lock_d  = 1'b0;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TmrW'(1);
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // Output logic: req_ready is combinational, UART port comes straight from registers.
    always_comb begin
        req_ready = '0;
        unique case (state_q)
            StIdle:  req_ready = pick_gnt;
`ifdef SER_ARB_LOCK_EN
            StLock:  req_ready = bus.req_valid & owner_oh;
`endif
            default: req_ready = '0;
        endcase
    end

    assign bus.req_ready = req_ready;
    assign bus.uart_we   = (state_q == StSend);
    assign bus.uart_dat  = hold_q;
    assign bus.owner     = owner_q;
`ifdef SER_ARB_LOCK_EN
    assign bus.locked    = lock_q;
`else
    assign bus.locked    = 1'b0;
`endif

endmodule

// File: tb/tb_ser_tx_arbiter.sv
// tb_ser_tx_arbiter: directed self-checking bench for ser_tx_arbiter (NUM_REQ=2,
// LOCK_TIMEOUT=16). Inputs change just after the falling edge; outputs are
// checked 1 ns later, far from the rising edge. Lock scenarios run when
// SER_ARB_LOCK_EN is defined, per-byte rotation scenarios otherwise.
module tb_ser_tx_arbiter;

    logic clk;
    logic resetn;
    int   n_cmp = 0;
    int   n_bad = 0;

    ser_tx_arbiter_if #(.NUM_REQ(2)) bus ();

    ser_tx_arbiter #(
        .NUM_REQ      (2),
        .LOCK_TIMEOUT (16)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        resetn        = 1'b0;
        bus.req_valid = 2'b00;
        bus.req_data  = 16'h0000;
        bus.uart_wait = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_we",    32'(bus.uart_we),   32'h0);
        chk("rst_dat",   32'(bus.uart_dat),  32'h00);
        chk("rst_owner", 32'(bus.owner),     32'h0);
        chk("rst_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_lock",  32'(bus.locked),    32'h0);

        // Single byte on lane 0
        @(negedge clk);
        resetn        = 1'b1;
        bus.req_valid = 2'b01;
        bus.req_data  = 16'h0041;
        #1 chk("t1_ready", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        bus.req_valid = 2'b00;
        #1;
        chk("t1_we",    32'(bus.uart_we),   32'h1);
        chk("t1_dat",   32'(bus.uart_dat),  32'h41);
        chk("t1_owner", 32'(bus.owner),     32'h0);
        chk("t1_ready_send", 32'(bus.req_ready), 32'h0);
        @(negedge clk);
        #1 chk("t1_we_done", 32'(bus.uart_we), 32'h0);

        // Clean reset before the next scenario
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        #1;
        chk("rst2_owner", 32'(bus.owner),   32'h0);
        chk("rst2_we",    32'(bus.uart_we), 32'h0);
        resetn = 1'b1;

        // Reset asserted mid-SEND drops the held byte
        @(negedge clk);
        bus.req_valid = 2'b10;
        bus.req_data  = 16'h7700;
        bus.uart_wait = 1'b1;
        #1 chk("rs_ready", 32'(bus.req_ready), 32'h2);
        @(negedge clk);
        bus.req_valid = 2'b00;
        #1;
        chk("rs_we_send", 32'(bus.uart_we),  32'h1);
        chk("rs_dat",     32'(bus.uart_dat), 32'h77);
        chk("rs_owner1",  32'(bus.owner),    32'h1);
        resetn = 1'b0;
        @(negedge clk);
        #1;
        chk("rs_we_rst",  32'(bus.uart_we),  32'h0);
        chk("rs_owner0",  32'(bus.owner),    32'h0);
        chk("rs_dat0",    32'(bus.uart_dat), 32'h00);
        resetn        = 1'b1;
        bus.uart_wait = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk("rs_no_resend", 32'(bus.uart_we), 32'h0);
        end

`ifdef SER_ARB_LOCK_EN
        // "hi\n" from lane 1 while lane 0 is always valid
        @(negedge clk);
        bus.req_valid = 2'b11;
        bus.req_data  = 16'h6830;
        #1 chk("lk_ready_h", 32'(bus.req_ready), 32'h2);
        @(negedge clk);
        bus.req_data = 16'h6930;
        #1;
        chk("lk_dat_h",  32'(bus.uart_dat), 32'h68);
        chk("lk_we_h",   32'(bus.uart_we),  32'h1);
        chk("lk_lock_h", 32'(bus.locked),   32'h0);
        @(negedge clk);
        #1;
        chk("lk_locked1", 32'(bus.locked),    32'h1);
        chk("lk_ready_i", 32'(bus.req_ready), 32'h2);
        @(negedge clk);
        bus.req_data = 16'h0A30;
        #1;
        chk("lk_dat_i",  32'(bus.uart_dat), 32'h69);
        chk("lk_lock_i", 32'(bus.locked),   32'h1);
        @(negedge clk);
        #1 chk("lk_ready_lf", 32'(bus.req_ready), 32'h2);
        @(negedge clk);
        bus.req_valid = 2'b01;
        #1;
        chk("lk_dat_lf",   32'(bus.uart_dat), 32'h0A);
        chk("lk_owner_lf", 32'(bus.owner),    32'h1);
        @(negedge clk);
        #1;
        chk("lk_unlocked", 32'(bus.locked),    32'h0);
        chk("lk_ready_l0", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        bus.req_valid = 2'b10;
        bus.req_data  = 16'h3130;
        #1;
        chk("lk_dat_30",   32'(bus.uart_dat), 32'h30);
        chk("lk_owner_30", 32'(bus.owner),    32'h0);

        // Lane 0 idles while locked: lock holds 16 cycles, then lane 1 wins
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            #1;
            chk("to_locked", 32'(bus.locked),    32'h1);
            chk("to_ready0", 32'(bus.req_ready), 32'h0);
        end
        @(negedge clk);
        #1;
        chk("to_released", 32'(bus.locked),    32'h0);
        chk("to_ready1",   32'(bus.req_ready), 32'h2);
        @(negedge clk);
        bus.req_valid = 2'b00;
        #1;
        chk("to_dat",   32'(bus.uart_dat), 32'h31);
        chk("to_owner", 32'(bus.owner),    32'h1);
`else
        // Both lanes always valid: strict rotation starting at lane 1
        begin
            logic [7:0] exp_seq [4];
            exp_seq[0] = 8'h31;
            exp_seq[1] = 8'h30;
            exp_seq[2] = 8'h31;
            exp_seq[3] = 8'h30;
            @(negedge clk);
            bus.req_valid = 2'b11;
            bus.req_data  = 16'h3130;
            for (int i = 0; i < 4; i++) begin
                #1 chk("rr_ready", 32'(bus.req_ready), (i % 2 == 0) ? 32'h2 : 32'h1);
                @(negedge clk);
                #1;
                chk("rr_we",    32'(bus.uart_we),   32'h1);
                chk("rr_dat",   32'(bus.uart_dat),  32'(exp_seq[i]));
                chk("rr_lock",  32'(bus.locked),    32'h0);
                chk("rr_ready_send", 32'(bus.req_ready), 32'h0);
                if (i == 3) bus.req_valid = 2'b00;
                @(negedge clk);
            end
            #1 chk("rr_idle", 32'(bus.uart_we), 32'h0);
        end

        // UART busy for 10 cycles: output stable 11 cycles, no ready pulses
        @(negedge clk);
        bus.req_valid = 2'b01;
        bus.req_data  = 16'h3155;
        bus.uart_wait = 1'b1;
        #1 chk("st_ready", 32'(bus.req_ready), 32'h1);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            bus.req_valid = 2'b11;
            #1;
            chk("st_we",    32'(bus.uart_we),   32'h1);
            chk("st_dat",   32'(bus.uart_dat),  32'h55);
            chk("st_ready_send", 32'(bus.req_ready), 32'h0);
            if (k == 11) bus.uart_wait = 1'b0;
        end
        @(negedge clk);
        #1;
        chk("st_we_done", 32'(bus.uart_we),   32'h0);
        chk("st_next",    32'(bus.req_ready), 32'h2);
        // Valid withdrawn before the edge: byte must not be taken
        bus.req_valid = 2'b00;
        @(negedge clk);
        #1;
        chk("st_withdraw_we",    32'(bus.uart_we), 32'h0);
        chk("st_withdraw_owner", 32'(bus.owner),   32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ser_tx_arbiter.md
# ser_tx_arbiter

Round-robin arbiter that shares the single simpleuart transmitter among `NUM_REQ` byte-stream requesters, such as the CPU console path and a hardware debug/trace source. It sits between the requesters and the UART data-register write port (`reg_dat_we` / `reg_dat_di` / `reg_dat_wait`). It holds each granted byte until the UART accepts it. Optionally it keeps a grant until end-of-line, so text lines from different sources never interleave on `ser_tx`.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters, legal range 2..4.
- `LOCK_TIMEOUT`, default 4096: cycles a line lock survives with its owner idle; only used with the lock feature.

Ports:
- `clk`, input, 1: system clock.
- `resetn`, input, 1: one clock; reset is synchronous and active-low.
- `req_valid`, input, `NUM_REQ`: requester i has a byte on its lane.
- `req_data`, input, `8*NUM_REQ`: byte lanes; lane i is bits [8i+7:8i].
- `req_ready`, output, `NUM_REQ`: byte on lane i is taken this cycle (one-hot or zero).
- `uart_we`, output, 1: write strobe to the UART data register.
- `uart_dat`, output, 8: byte to transmit.
- `uart_wait`, input, 1: UART busy; a write is accepted in a cycle with `uart_we` high and `uart_wait` low.
- `owner`, output, `$clog2(NUM_REQ)`: index of the last or current grantee.
- `locked`, output, 1: a line lock is active.

## Operation
- States:
  - IDLE: no byte held.
  - SEND: byte held and `uart_we` asserted.
  - LOCK: only with `SER_ARB_LOCK_EN`.
- IDLE:
  - The round-robin pick starts at `(owner+1) mod NUM_REQ`.
  - The first i with `req_valid[i]` gets `req_ready[i]=1` combinationally in the same cycle.
  - At the edge: the byte is latched into `hold`, `owner<=i`, and the state goes to SEND.
  - With no valid requester, the state stays IDLE and all `req_ready` are 0.
- SEND:
  - `uart_we=1` and `uart_dat=hold`, both held stable.
  - All `req_ready` are 0.
  - On a cycle with `uart_wait==0`, the byte is done. Next state is IDLE, or LOCK under the rules in Configuration.
- `req_valid` may drop before its grant with no effect; the byte is never taken.
- Requesters must hold data stable while valid.
- Because `owner` updates only on grant, the requester just served becomes lowest priority.

## Timing
- Reset values, all at the first `clk` edge with `resetn=0`:
  - state = IDLE
  - `owner=0`, so requester 1 has first priority after reset
  - `hold=8'h00`
  - `uart_we=0`, `uart_dat=8'h00`
  - `req_ready=0`, `locked=0`
  - lock timer = 0
- Latency:
  - Byte accepted in cycle N gives `uart_we` high in cycle N+1.
  - Best case one byte every 2 cycles, which is far above UART rate.
- `uart_we` and `uart_dat` are registered. `req_ready` is combinational from `req_valid`, state and `owner`.
- Reset asserted mid-SEND: the held byte is dropped and `uart_we` is low after that edge. The UART may still finish any frame already started.
- `uart_wait` high for an unbounded time: the arbiter stays in SEND. There is no timeout in SEND.
- `req_valid` high on all lanes continuously: strict rotation 0,1,..,NUM_REQ-1 (starting at 1 after reset), one byte per grant.

## Configuration
- Macro `SER_ARB_LOCK_EN`.
- Defined:
  - After a SEND completes with `hold != 8'h0A`, the next state is LOCK and `locked=1`.
  - In LOCK, only `req_ready[owner]` may assert, granting straight into SEND.
  - A byte `8'h0A` (LF) completing SEND returns to IDLE and releases the lock.
  - A lock timer counts cycles in LOCK while `req_valid[owner]==0`. It clears on each owner grant.
  - When the timer reaches `LOCK_TIMEOUT-1`, the next state is IDLE, the lock is released and the timer is cleared.
  - The width of the timer is `$clog2(LOCK_TIMEOUT)`.
- Undefined:
  - No LOCK state, no timer, and `locked` is tied to 0.
  - Every completed SEND returns to IDLE, giving per-byte round robin.

## Structure
- Package `ser_arb_pkg`:
  - state enum (IDLE/SEND/LOCK)
  - `ASCII_LF = 8'h0A`
  - `NUM_REQ_MAX = 4`
- Sub-module `rr_pick`:
  - Combinational round-robin priority picker.
  - Inputs: request vector and start index.
  - Outputs: one-hot grant, grant index, any-valid.
- The top level holds the FSM, the hold register and the lock timer.

## Test plan
- Reset, then `req_valid=2'b01`, `req_data[7:0]=8'h41`, `uart_wait=0` → `req_ready=2'b01` in the same cycle. Next cycle `uart_we=1`, `uart_dat=8'h41` for exactly 1 cycle, and `owner=0`.
- Both lanes always valid (lane0 `8'h30`, lane1 `8'h31`), `uart_wait=0`, lock off → `uart_dat` sequence 31,30,31,30.
- `uart_wait` high 10 cycles after grant → `uart_we` and `uart_dat` stable for 11 cycles. No `req_ready` pulses meanwhile.
- Lock on, `NUM_REQ=2`: lane1 sends "hi\n" while lane0 is always valid → bytes 68,69,0A from lane1 are uninterrupted. The next grant goes to lane0.
- Lock on, `LOCK_TIMEOUT=16`: lane0 sends `8'h61`, then idles while lane1 is valid → `locked` drops 16 cycles after LOCK entry. lane1 is then granted.
- `resetn` low during SEND → `uart_we=0`, state IDLE and `owner=0` at the next edge. The held byte is never re-sent.
